mult_n_seq: RTL

//  Parametrised sequential shift-add multiply-accumulate: res = a*b + c, 2*WIDTH-bit result.

---
 rtl/mult_n_seq_if.sv | 29 ++
 rtl/mult_n_seq.sv | 98 +++++++++
 2 files changed

// File: rtl/mult_n_seq_if.sv
// mult_n_seq_if: handshake and operand/result bundle for the mult_n_seq
// multiply-accumulate unit.
//   activate         start request (master -> slave)
//   a, b, c          multiplicand, multiplier, addend (master -> slave)
//   busy             unit is in RUN or DONE (slave -> master)
//   done             one-cycle result-valid pulse (slave -> master)
//   res_lo, res_hi   low/high halves of a*b+c (slave -> master)
interface mult_n_seq_if #(
  parameter int WIDTH = 8
);
  logic             activate;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;

  modport master (
    output activate, a, b, c,
    input  busy, done, res_lo, res_hi
  );

  modport slave (
    input  activate, a, b, c,
    output busy, done, res_lo, res_hi
  );
endinterface

// File: rtl/mult_n_seq.sv
// mult_n_seq: sequential shift-add multiply-accumulate, res = a*b + c with a
// 2*WIDTH-bit result, one multiplier bit per clock.
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous, active-high reset
//   bus     mult_n_seq_if.slave (activate, a, b, c in; busy, done,
//           res_lo, res_hi out), all outputs registered
// Optional feature: define MULT_EARLY_EXIT_EN to leave RUN as soon as the
// remaining multiplier bits are all zero; the result is unchanged.
module mult_n_seq #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  mult_n_seq_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               last;

  // One shift-add iteration for multiplier bit cnt.
  always_comb begin
    acc_nxt = acc;
    if (op_b[cnt]) begin
      acc_nxt = acc + ({{WIDTH{1'b0}}, op_a} << cnt);
    end
  end

`ifdef MULT_EARLY_EXIT_EN
  // Finish once no set multiplier bit remains above the current one.
  always_comb begin
    last = (cnt == CNT_W'(WIDTH - 1)) || ((op_b >> (32'(cnt) + 32'd1)) == '0);
  end
`else
  always_comb begin
    last = (cnt == CNT_W'(WIDTH - 1));
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      op_a        <= '0;
      op_b        <= '0;
      acc         <= '0;
      cnt         <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.res_lo  <= '0;
      bus.res_hi  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.activate) begin
            op_a     <= bus.a;
            op_b     <= bus.b;
            acc      <= {{WIDTH{1'b0}}, bus.c};
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (last) begin
            bus.done   <= 1'b1;
            bus.res_lo <= acc_nxt[WIDTH-1:0];
            bus.res_hi <= acc_nxt[2*WIDTH-1:WIDTH];
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
